// File: rtl/spike_count_classifier_pkg.sv
// Shared types for the output-layer spike classifier.
// State encoding, default widths and the per-neuron count type.
package spike_count_classifier_pkg;

    localparam int DEF_NUM_NEURONS = 10;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_WIN_W       = 16;

    typedef logic [DEF_CNT_W-1:0] spike_cnt_t;

    localparam spike_cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SCAN,
        RESULT
    } cls_state_e;

endpackage

// File: rtl/spike_count_classifier_counter.sv
// Saturating per-neuron spike counter.
// Clear wins over increment; the count never wraps.
module spike_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic         at_max;

    assign at_max = &cnt_q;

    // count up on each spike, hold at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Output-layer decoder: counts spikes over a window, then
// scans the counts sequentially for the winning class.
module spike_count_classifier
    import spike_count_classifier_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIN_W-1:0]               window_len,
    input  logic [NUM_NEURONS-1:0]         spike_in,
    output logic                           busy,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [$clog2(NUM_NEURONS)-1:0] winner_idx,
    output logic [CNT_W-1:0]               winner_count,
    output logic                           tie
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    cls_state_e state_q;
    cls_state_e state_d;

    logic [WIN_W-1:0] win_q;
    logic [IDX_W-1:0] scan_q;
    logic [CNT_W-1:0] cnt [NUM_NEURONS];
    logic [CNT_W-1:0] sel_cnt;

    logic [CNT_W-1:0] best_q;
    logic [CNT_W-1:0] best_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             tie_q;
    logic             tie_d;

    logic [IDX_W-1:0] out_idx_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_tie_q;

    logic start_ok;
    logic count_en;
    logic scan_en;
    logic scan_last;
    logic win_last;

    assign start_ok  = (state_q == IDLE) && start;
    assign count_en  = (state_q == COUNT);
    assign scan_en   = (state_q == SCAN);
    assign win_last  = (win_q == WIN_W'(1));
    assign scan_last = scan_en && (scan_q == LAST_IDX);

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_cnt
            spike_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .clear(start_ok),
                .inc  (count_en && spike_in[g]),
                .count(cnt[g])
            );
        end
    endgenerate

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: IDLE -> COUNT -> SCAN -> RESULT -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (win_last) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_q == LAST_IDX) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // window down-counter; zero length is promoted to one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (start_ok) begin
            win_q <= (window_len == '0) ? WIN_W'(1) : window_len;
        end else if (count_en) begin
            win_q <= win_q - WIN_W'(1);
        end
    end

    // scan index walks 0..NUM_NEURONS-1 once per window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
        end else if (start_ok) begin
            scan_q <= '0;
        end else if (scan_en && !scan_last) begin
            scan_q <= scan_q + IDX_W'(1);
        end
    end

    // pick the count under the scan pointer
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (scan_q == k[IDX_W-1:0]) begin
                sel_cnt = cnt[k];
            end
        end
    end

    // one argmax step; strict > keeps the lowest index on ties
    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        tie_d  = tie_q;
        if (scan_q == '0) begin
            best_d = sel_cnt;
            idx_d  = '0;
            tie_d  = 1'b0;
        end else if (sel_cnt > best_q) begin
            best_d = sel_cnt;
            idx_d  = scan_q;
            tie_d  = 1'b0;
        end else if (sel_cnt == best_q) begin
            tie_d  = 1'b1;
        end
    end

    // running argmax registers, updated during SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '0;
            idx_q  <= '0;
            tie_q  <= 1'b0;
        end else if (scan_en) begin
            best_q <= best_d;
            idx_q  <= idx_d;
            tie_q  <= tie_d;
        end
    end

    // published result, held until the next scan finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q <= '0;
            out_cnt_q <= '0;
            out_tie_q <= 1'b0;
        end else if (scan_last) begin
            out_idx_q <= idx_d;
            out_cnt_q <= best_d;
            out_tie_q <= tie_d;
        end
    end

    assign busy         = count_en || scan_en;
    assign result_valid = (state_q == RESULT);
    assign winner_idx   = out_idx_q;
    assign winner_count = out_cnt_q;
    assign tie          = out_tie_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier.
// Drives and samples on the falling edge.
module tb_spike_count_classifier;

    localparam int N = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   window_len = '0;
    logic [N-1:0]  spike_in = '0;
    logic          busy;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [3:0]    winner_idx;
    logic [7:0]    winner_count;
    logic          tie;

    int n_checks = 0;
    int n_errors = 0;

    spike_count_classifier #(
        .NUM_NEURONS(N),
        .CNT_W      (8),
        .WIN_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .window_len  (window_len),
        .spike_in    (spike_in),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .winner_idx  (winner_idx),
        .winner_count(winner_count),
        .tie         (tie)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one window: mask spikes for the first act cycles; an extra
    // start pulse at COUNT cycle ign_at (if >= 1) must be ignored
    task automatic run_window(input string tag, input int wl,
                              input logic [N-1:0] mask,
                              input int act, input int ign_at,
                              input int e_idx, input int e_cnt,
                              input int e_tie, input bit hold);
        int len;
        int cyc;
        len = (wl == 0) ? 1 : wl;
        @(negedge clk);
        window_len = 16'(wl);
        start = 1'b1;
        spike_in = '0;
        cyc = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            cyc++;
            start = (k == ign_at) ? 1'b1 : 1'b0;
            window_len = (k == ign_at) ? 16'd2 : 16'(wl);
            spike_in = (k < act) ? mask : '0;
            if (k == 0) chk({tag, " busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        cyc++;
        start = 1'b0;
        spike_in = '0;
        while (!result_valid && cyc < len + N + 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(len + N + 1));
        chk({tag, " valid"}, 32'(result_valid), 32'd1);
        chk({tag, " idx"}, 32'(winner_idx), 32'(e_idx));
        chk({tag, " count"}, 32'(winner_count), 32'(e_cnt));
        chk({tag, " tie"}, 32'(tie), 32'(e_tie));
        chk({tag, " busy_res"}, 32'(busy), 32'd0);
        if (!hold) begin
            @(negedge clk);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk({tag, " valid_drop"}, 32'(result_valid), 32'd0);
            chk({tag, " idx_keep"}, 32'(winner_idx), 32'(e_idx));
        end
    endtask

    initial begin
        #2;
        chk("rst valid", 32'(result_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst idx", 32'(winner_idx), 32'd0);
        chk("rst count", 32'(winner_count), 32'd0);
        chk("rst tie", 32'(tie), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_window("t1", 20, N'(1 << 3), 20, -1, 3, 20, 0, 1'b0);
        run_window("t2", 10, N'((1 << 2) | (1 << 7)), 5, -1,
                   2, 5, 1, 1'b0);
        run_window("t3", 300, N'(1), 300, -1, 0, 255, 0, 1'b0);
        run_window("t4", 0, '0, 0, -1, 0, 0, 1, 1'b0);

        run_window("t5", 8, N'(1 << 5), 4, 3, 5, 4, 0, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = c[0];
            chk("t5 hold valid", 32'(result_valid), 32'd1);
            chk("t5 hold idx", 32'(winner_idx), 32'd5);
            chk("t5 hold count", 32'(winner_count), 32'd4);
        end
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("t5 release valid", 32'(result_valid), 32'd0);
        chk("t5 release busy", 32'(busy), 32'd0);

        @(negedge clk);
        window_len = 16'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        spike_in = N'(1 << 4);
        repeat (3) @(negedge clk);
        chk("t6 busy pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst valid", 32'(result_valid), 32'd0);
        chk("t6 rst idx", 32'(winner_idx), 32'd0);
        chk("t6 rst count", 32'(winner_count), 32'd0);
        chk("t6 rst tie", 32'(tie), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spike_in = '0;
        @(negedge clk);
        chk("t6 idle valid", 32'(result_valid), 32'd0);
        run_window("t6", 12, N'(1 << 9), 7, -1, 9, 7, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
